serial_bit_feeder: RTL

- Parallel-to-serial stage directly upstream of the 101 sequence detector.
- Accepts a WIDTH-bit word through a valid/ready handshake and emits it one bit per clock on d_out, which drives the detector's d_in.
- Inserts a configurable idle gap between frames and flags frame boundaries for downstream logging and checking.

---
 rtl/serial_bit_feeder_if.sv | 25 ++
 rtl/serial_bit_feeder.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/serial_bit_feeder_if.sv
// serial_bit_feeder_if: word-load handshake between a producer and serial_bit_feeder.
//   data_in    - word to serialize, sampled only on a transfer
//   load_valid - producer has a word on data_in
//   load_ready - feeder can accept a word this cycle
// A transfer happens on a clk edge where load_valid && load_ready.
// Modports: master = producer side, slave = feeder side.
interface serial_bit_feeder_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;

  modport master (
    output data_in,
    output load_valid,
    input  load_ready
  );

  modport slave (
    input  data_in,
    input  load_valid,
    output load_ready
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial stage feeding the 101 sequence detector.
// Accepts a WIDTH-bit word on a valid/ready handshake and sends it one bit per clock on d_out,
// followed by GAP_CYCLES idle cycles. Optional even parity bit when the macro
// SERIAL_BIT_FEEDER_PARITY_EN is defined (frame grows to WIDTH+1 bits).
// Ports:
//   clk         - clock, rising edge
//   reset       - synchronous active-high reset
//   load        - handshake interface (slave): data_in, load_valid, load_ready
//   d_out       - registered serial bit, IDLE_LEVEL outside frame bits
//   bit_valid   - d_out carries a frame bit (data or parity)
//   frame_start - pulse with the first bit of a frame
//   frame_done  - pulse with the last bit of a completed frame
//   busy        - in SHIFT or GAP
module serial_bit_feeder #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned MSB_FIRST  = 1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic               clk,
  input  logic               reset,
  serial_bit_feeder_if.slave load,
  output logic               d_out,
  output logic               bit_valid,
  output logic               frame_start,
  output logic               frame_done,
  output logic               busy
);

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  localparam int unsigned FrameLen = WIDTH + 1;
`else
  localparam int unsigned FrameLen = WIDTH;
`endif
  localparam int unsigned CntW = $clog2(FrameLen);
  localparam int unsigned GapW = 4;
  localparam logic [CntW-1:0] LastBit = CntW'(FrameLen - 1);
  // Only meaningful when HasGap; wraps harmlessly otherwise.
  localparam logic [GapW-1:0] LastGap = GapW'(GAP_CYCLES - 1);
  localparam bit HasGap   = (GAP_CYCLES != 0);
  localparam bit MsbFirst = (MSB_FIRST != 0);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CntW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  logic             par_q, par_d;
`endif

  logic             d_out_d, bit_valid_d, frame_start_d, frame_done_d;
  logic             xfer, last_bit, last_gap;
  logic             first_bit, next_bit;
  logic [WIDTH-1:0] load_rest, shift_rest;

  assign last_bit = (bit_cnt_q == LastBit);
  assign last_gap = (gap_cnt_q == LastGap);

  // Ready depends on state and counters only, never on load_valid.
  always_comb begin
    unique case (state_q)
      StIdle:  load.load_ready = 1'b1;
      StShift: load.load_ready = !HasGap && last_bit;
      StGap:   load.load_ready = last_gap;
      default: load.load_ready = 1'b0;
    endcase
  end

  assign xfer = load.load_valid && load.load_ready;
  assign busy = (state_q != StIdle);

  // The first bit goes straight to d_out on the accepting edge; the shift register keeps
  // only the bits still to be sent, so its head is always the next bit.
  assign first_bit  = MsbFirst ? load.data_in[WIDTH-1] : load.data_in[0];
  assign load_rest  = MsbFirst ? (load.data_in << 1) : (load.data_in >> 1);
  assign next_bit   = MsbFirst ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shift_rest = MsbFirst ? (shreg_q << 1) : (shreg_q >> 1);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
      par_q       <= 1'b0;
`endif
      d_out       <= IDLE_LEVEL;
      bit_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
      par_q       <= par_d;
`endif
      d_out       <= d_out_d;
      bit_valid   <= bit_valid_d;
      frame_start <= frame_start_d;
      frame_done  <= frame_done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    gap_cnt_d = gap_cnt_q;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    par_d     = par_q;
`endif
    if (xfer) begin
      // A transfer can only land in IDLE or the final cycle of a frame.
      state_d   = StShift;
      shreg_d   = load_rest;
      bit_cnt_d = '0;
      gap_cnt_d = '0;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
      par_d     = ^load.data_in;
`endif
    end else begin
      unique case (state_q)
        StIdle: ;
        StShift: begin
          if (!last_bit) begin
            bit_cnt_d = bit_cnt_q + CntW'(1);
            shreg_d   = shift_rest;
          end else begin
            bit_cnt_d = '0;
            gap_cnt_d = '0;
            state_d   = HasGap ? StGap : StIdle;
          end
        end
        StGap: begin
          if (!last_gap) begin
            gap_cnt_d = gap_cnt_q + GapW'(1);
          end else begin
            gap_cnt_d = '0;
            state_d   = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // Output logic: next values of the registered serial outputs
  always_comb begin
    d_out_d       = IDLE_LEVEL;
    bit_valid_d   = 1'b0;
    frame_start_d = 1'b0;
    frame_done_d  = 1'b0;
    if (state_d == StShift) begin
      bit_valid_d   = 1'b1;
      frame_start_d = xfer;
      frame_done_d  = (bit_cnt_d == LastBit);
      if (xfer) begin
        d_out_d = first_bit;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
      end else if (bit_cnt_d == CntW'(WIDTH)) begin
        d_out_d = par_q;
`endif
      end else begin
        d_out_d = next_bit;
      end
    end
  end

endmodule
